// File: rtl/fetch_queue.sv
// fetch_queue: PC-owning fetch stage buffering {PC, instr} pairs in a DEPTH-entry queue with redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to hand imem_data straight to decode while the queue is empty.
module fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_W-1:0]         dec_instr,
    output logic [ADDR_W-1:0]          dec_pc,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      cnt;
    logic               empty, bypass, take, pop, push;

    assign empty = cnt == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Gated by reset so outputs read as idle while reset is held.
    assign bypass = empty && !redirect && !reset;
`else
    assign bypass = 1'b0;
`endif
    assign dec_valid = !empty || bypass;
    assign dec_instr = !empty ? q_instr[rd_ptr] : bypass ? imem_data : '0;
    assign dec_pc    = !empty ? q_pc[rd_ptr] : bypass ? pc : '0;
    assign take      = bypass && dec_ready;
    assign pop       = !empty && dec_ready;
    assign push      = (cnt < CW'(DEPTH) || pop) && !redirect && !take;
    assign imem_addr = pc;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push || take)
                pc <= pc + ADDR_W'(4);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the pipelined ARM64 CPU. It owns the program counter, drives the instruction-memory address, and buffers fetched {PC, instruction} pairs in a DEPTH-entry queue. Decode consumes entries through a valid/ready handshake. A single-cycle redirect port takes taken branches: it flushes the queue and reloads the PC. The block replaces the fixed single-register IFETCH→DECODE hand-off, letting fetch run ahead of a stalled decode.

## Interface
- ADDR_W, 64, PC / instruction-address width
- INSTR_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- imem_addr  output  ADDR_W  fetch address; always equals the PC register
- imem_data  input  INSTR_W  instruction at imem_addr; combinational memory, valid in the same cycle
- dec_valid  output  1  head entry available to decode
- dec_ready  input  1  decode accepts head this cycle
- dec_instr  output  INSTR_W  head instruction
- dec_pc  output  ADDR_W  head PC
- redirect  input  1  taken branch; flush and reload PC
- redirect_pc  input  ADDR_W  new PC; bits [1:0] are ignored and forced to 0
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Reset values:
  - PC = RESET_PC; imem_addr = RESET_PC.
  - Queue empty; count = 0.
  - dec_valid = 0; dec_instr = 0; dec_pc = 0.
  - Read and write pointers = 0.
- Pop: occurs when dec_valid && dec_ready.
- Push: occurs when (count < DEPTH || pop) && !redirect.
  - Writes {PC, imem_data} at the write pointer.
  - PC advances by 4, modulo 2^ADDR_W (wraps 2^ADDR_W−4 → 0).
- Full with no pop: no push; PC holds.
- Redirect has priority over push:
  - A head pop handshaked in the same cycle completes normally.
  - All other entries are discarded; count becomes 0; pointers reset to 0.
  - PC becomes {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No entry is written in the redirect cycle.
- Head outputs: dec_instr and dec_pc come from queue storage at the read pointer.
  - When empty, they are 0 (bypass off) or take the bypass path below.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- count updates by +1 on push only, −1 on pop only, and 0 on push and pop together.

## Timing
- Fetch-to-decode latency without bypass: 1 cycle. A word fetched in cycle N shows at the head in cycle N+1 at the earliest.
- Throughput: 1 instruction per cycle sustained while dec_ready = 1.
- Redirect asserted in cycle N:
  - dec_valid = 0 in cycle N+1 (without bypass).
  - imem_addr = redirect_pc in cycle N+1.
  - The first post-redirect entry is valid in cycle N+2.
- Full and pop in the same cycle: push still occurs; count stays at DEPTH.
- Reset asserted mid-operation: all state clears asynchronously and outputs reach their reset values without waiting for a clock edge.
- dec_valid and the head fields depend only on flops, except on the bypass path.

## Configuration
- FETCH_QUEUE_BYPASS_EN
  - Defined: when count = 0 and !redirect, dec_valid = 1 combinationally and dec_instr = imem_data, dec_pc = PC.
    - If dec_ready = 1, the word is consumed directly: no push, PC += 4, 0-cycle latency.
    - If dec_ready = 0, a normal push occurs.
  - Undefined: no bypass path; dec_valid = 0 whenever count = 0; the 1-cycle latency always applies.

## Test plan
- Reset check: pulse reset between clock edges with RESET_PC=0 → immediately imem_addr=0, count=0, dec_valid=0, dec_pc=0.
- Back-pressure fill: hold dec_ready=0 for 6 cycles, memory returning word = address → count goes 1,2,3,4,4; PC stops at 0x10; head is dec_pc=0, dec_instr=0.
- Drain plus streaming: from full, set dec_ready=1 → dec_pc goes 0,4,8,… one per cycle with no gaps; count stays 4 while PC advances.
- Redirect mid-stream: with count=3, assert redirect with redirect_pc=0x1003 → next cycle count=0 and imem_addr=0x1000; two cycles later dec_pc=0x1000 (without bypass).
- PC wrap: RESET_PC=2^64−8, dec_ready=1 → dec_pc goes 2^64−8, 2^64−4, 0, 4.
- Bypass (FETCH_QUEUE_BYPASS_EN defined), queue empty, dec_ready=1 → dec_valid=1 in the same cycle with dec_pc=imem_addr, and count stays 0. Without the macro, the same stimulus gives dec_valid=0 in the first cycle.
